seg7_varredura: RTL and testbench
=================================

# seg7_varredura

Time-multiplexed 4-digit seven-segment display driver, directly downstream of the binary-to-BCD converter. Captures the converter's four BCD digits on the `escrever` strobe, holds them, and scans the digits onto a shared segment bus with per-digit enables. It also provides anti-ghosting guard time and optional leading-zero blanking. It is the last stage before the board's display pins.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `GUARD`, 500: cycles at the start of each slot with all digits disabled; must be < `CLK_DIV`.
- `BLANK_LZ`, 1: 1 = blank leading zeros; units digit is never blanked.
- `SEG_ACTIVE_LOW`, 1: 1 = segment outputs low-true.
- `AN_ACTIVE_LOW`, 1: 1 = digit enables low-true.
- `clock`, in, 1: single system clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `escrever`, in, 1: capture strobe; digits are sampled on every rising edge where it is 1.
- `setseg1`, in, 4: units BCD digit.
- `setseg2`, in, 4: tens BCD digit.
- `setseg3`, in, 4: hundreds BCD digit.
- `setseg4`, in, 4: thousands BCD digit.
- `segmentos`, out, 7: segment drive; bit 0 = a … bit 6 = g.
- `anodos`, out, 4: digit enables; bit k selects digit k (0 = units).

## Operation
- **Capture register** `dig[3:0]` (4 bits each), reset 0.
  - On a clock edge with `escrever`=1: `dig[0..3]` ← `setseg1..4`.
  - When `escrever`=0, the register holds and input changes are ignored.
- **Slot counter** `cnt`, width clog2(`CLK_DIV`), reset 0.
  - Increments every cycle.
  - At `CLK_DIV`-1 it wraps to 0 and the 2-bit index `idx` increments, wrapping 3→0.
  - `idx` reset value is 0.
- **Blank condition** for digit `idx`: `BLANK_LZ`=1, `idx`≠0, and `dig[j]`==0 for all j ≥ `idx`.
- **Decode**, active-high pattern before polarity:
  - 0: 0111111
  - 1: 0000110
  - 2: 1011011
  - 3: 1001111
  - 4: 1100110
  - 5: 1101101
  - 6: 1111101
  - 7: 0000111
  - 8: 1111111
  - 9: 1101111
  - 10–15: dash, 1000000
  - Blank: 0000000
- **Enables**, active-high before polarity:
  - All off while `cnt` < `GUARD`.
  - All off when the current digit is blanked.
  - Otherwise one-hot on `idx`.
- **Outputs** are registered and inverted per the polarity parameters. They reflect the previous cycle's `cnt`, `idx` and `dig`.

## Timing
- **Reset:** asynchronous; takes effect immediately, including mid-slot or mid-capture.
  - `anodos` = all inactive (4'b1111 with defaults).
  - `segmentos` = all off (7'b1111111 with defaults).
  - `dig`, `cnt` and `idx` clear to 0.
- **Latency:**
  - `escrever` at edge N: the new value appears on the outputs at edge N+1 if the current slot is past its guard.
  - Mid-slot updates are allowed; there is no wait for a slot boundary.
- **Slot period:** `CLK_DIV` cycles; full refresh is 4×`CLK_DIV`.
  - The first `GUARD` output cycles of each slot are dark.
- **Continuous strobe:** `escrever` held high tracks the inputs every cycle.
- **Capture vs. wrap:** capture and index wrap in the same cycle are independent; the new `idx` uses the new `dig`.
- **Non-BCD input:** shows a dash and is never blanked. Leading-zero evaluation compares for == 0 only.

## Structure
- **Shared display package:**
  - Seven segment pattern constants, 0–9, dash and blank.
  - Digit count constant, 4.
  - Decode function returning the active-high pattern.
- **Sub-module `bcd_para_7seg`:** purely combinational, 4-bit digit plus blank flag in, 7-bit active-high pattern out. It is instantiated once on the muxed digit.
- **Top level holds:** capture register, counter/index, blanking logic, polarity inversion and output registers.

## Test plan
All scenarios use `CLK_DIV`=4 and `GUARD`=1 with default polarities.
- **Reset:** hold `reset_n`=0 for 3 cycles → `anodos`=1111, `segmentos`=1111111. Release → first enabled output is `anodos`=1110 with segments for 0 (1000000), because `dig`=0 and the units digit is never blanked.
- **Normal scan:** pulse `escrever` with `setseg4..1`=1,2,3,4 → over 16 cycles each slot shows 1 dark cycle, then 3 cycles of:
  - `anodos`=1110, `segmentos`=0011001 (4)
  - `anodos`=1101, `segmentos`=0110000 (3)
  - `anodos`=1011, `segmentos`=0100100 (2)
  - `anodos`=0111, `segmentos`=1111001 (1)
- **Leading zeros:** capture 0,0,0,7 → only the units slot enables (`anodos`=1110, `segmentos`=1111000); slots 1–3 stay at 1111. Capture 0,4,0,0 → digits 0–2 shown, digit 3 dark.
- **Hold and invalid digit:** `escrever`=0 while the inputs change → outputs unchanged for a full refresh. Capture `setseg1`=12 → units shows a dash, `segmentos`=0111111.
- **Reset mid-scan:** assert `reset_n` during slot 2 → outputs go to the reset values within the same cycle (async). After release, the scan restarts at slot 0 with `dig`=0.

Source files
------------

// File: rtl/seg7_varredura_pkg.sv
// Shared display constants and the digit-to-segment decode used by the scan driver.
// Patterns are active-high, bit 0 = a ... bit 6 = g.
package seg7_varredura_pkg;

   localparam int NUM_DIG = 4;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic blank);
      logic [6:0] p;
      case (d)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         4'd5:    p = SEG_5;
         4'd6:    p = SEG_6;
         4'd7:    p = SEG_7;
         4'd8:    p = SEG_8;
         4'd9:    p = SEG_9;
         default: p = SEG_DASH;
      endcase
      return blank ? SEG_BLANK : p;
   endfunction

endpackage

// File: rtl/seg7_varredura_bcd_para_7seg.sv
// Combinational BCD digit to active-high seven-segment pattern, with blank override.
module bcd_para_7seg
   import seg7_varredura_pkg::*;
(
   input  logic [3:0] digito,
   input  logic       apagar,
   output logic [6:0] padrao
);

   assign padrao = seg_decode(digito, apagar);

endmodule

// File: rtl/seg7_varredura.sv
// Four-digit multiplexed seven-segment driver: captures BCD digits on a strobe and
// scans them with a dark guard at the start of each slot and leading-zero blanking.
module seg7_varredura
   import seg7_varredura_pkg::*;
#(
   parameter int CLK_DIV        = 50000,
   parameter int GUARD          = 500,
   parameter bit BLANK_LZ       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       escrever,
   input  logic [3:0] setseg1,
   input  logic [3:0] setseg2,
   input  logic [3:0] setseg3,
   input  logic [3:0] setseg4,
   output logic [6:0] segmentos,
   output logic [3:0] anodos
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [NUM_DIG-1:0][3:0] dig;
   logic [CNT_W-1:0]        cnt;
   logic [1:0]              idx;
   logic [NUM_DIG-1:0]      zero_up;
   logic                    apagar;
   logic [6:0]              padrao;
   logic [3:0]              en;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dig <= '0;
      end else if (escrever) begin
         dig <= {setseg4, setseg3, setseg2, setseg1};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // zero_up[k]: every digit from k upward is zero, i.e. digit k is a leading zero
   always_comb begin
      zero_up[NUM_DIG-1] = (dig[NUM_DIG-1] == 4'd0);
      for (int j = NUM_DIG - 2; j >= 0; j--) begin
         zero_up[j] = (dig[j] == 4'd0) && zero_up[j+1];
      end
   end

   assign apagar = BLANK_LZ && (idx != 2'd0) && zero_up[idx];

   bcd_para_7seg u_dec (
      .digito (dig[idx]),
      .apagar (apagar),
      .padrao (padrao)
   );

   always_comb begin
      en = 4'b0000;
      if ((cnt >= CNT_W'(GUARD)) && !apagar) en = 4'b0001 << idx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         anodos    <= {4{AN_ACTIVE_LOW}};
         segmentos <= {7{SEG_ACTIVE_LOW}};
      end else begin
         anodos    <= en ^ {4{AN_ACTIVE_LOW}};
         segmentos <= padrao ^ {7{SEG_ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_seg7_varredura.sv
// Bench for seg7_varredura: per-cycle comparison against a time-indexed scan model,
// plus literal windowed expectations from the display's test scenarios.
module tb_seg7_varredura;

   localparam int CLK_DIV = 4;
   localparam int GUARD   = 1;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       escrever = 1'b0;
   logic [3:0] setseg1 = '0, setseg2 = '0, setseg3 = '0, setseg4 = '0;
   logic [6:0] segmentos;
   logic [3:0] anodos;

   seg7_varredura #(
      .CLK_DIV(CLK_DIV), .GUARD(GUARD), .BLANK_LZ(1'b1),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n), .escrever(escrever),
      .setseg1(setseg1), .setseg2(setseg2), .setseg3(setseg3), .setseg4(setseg4),
      .segmentos(segmentos), .anodos(anodos)
   );

   always #5 clock = ~clock;

   logic [6:0] pat [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                            7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

   // Model: t counts clock edges since reset; slot and position follow by division.
   int         t;
   logic [3:0] md [4];
   logic [3:0] exp_an;
   logic [6:0] exp_seg;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         t       <= 0;
         md      <= '{default: 4'd0};
         exp_an  <= 4'hF;
         exp_seg <= 7'h7F;
      end else begin
         automatic int pos  = t % CLK_DIV;
         automatic int slot = (t / CLK_DIV) % 4;
         automatic bit lead = 1'b1;
         automatic bit blank;
         for (int j = slot; j < 4; j++) if (md[j] != 4'd0) lead = 1'b0;
         blank   = (slot != 0) && lead;
         exp_seg <= blank ? 7'h7F : ~pat[md[slot]];
         exp_an  <= (pos >= GUARD && !blank) ? ~(4'(1) << slot) : 4'hF;
         if (escrever) md <= '{setseg1, setseg2, setseg3, setseg4};
         t <= t + 1;
      end
   end

   int tests = 0;
   int fails = 0;
   logic [3:0] oa [16];
   logic [6:0] os [16];

   task automatic chk(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step();
      @(negedge clock);
      chk("scan", {anodos, segmentos}, {exp_an, exp_seg});
   endtask

   task automatic capture(input logic [3:0] d4, d3, d2, d1);
      setseg4 = d4; setseg3 = d3; setseg2 = d2; setseg1 = d1;
      escrever = 1'b1;
      step();
      escrever = 1'b0;
   endtask

   task automatic window(input bit scramble);
      for (int i = 0; i < 16; i++) begin
         step();
         oa[i] = anodos;
         os[i] = segmentos;
         if (scramble) begin
            setseg1 = 4'($urandom); setseg2 = 4'($urandom);
            setseg3 = 4'($urandom); setseg4 = 4'($urandom);
         end
      end
   endtask

   function automatic int npair(input logic [3:0] a, input logic [6:0] s);
      int n = 0;
      for (int i = 0; i < 16; i++) if (oa[i] == a && os[i] == s) n++;
      return n;
   endfunction

   function automatic int ndark();
      int n = 0;
      for (int i = 0; i < 16; i++) if (oa[i] == 4'hF) n++;
      return n;
   endfunction

   task automatic release_and_check_zero(input string tag);
      reset_n = 1'b1;
      step();
      chk({tag, "_guard_an"}, anodos, 4'b1111);
      chk({tag, "_guard_seg"}, segmentos, 7'b1000000);
      step();
      chk({tag, "_first_an"}, anodos, 4'b1110);
      chk({tag, "_first_seg"}, segmentos, 7'b1000000);
   endtask

   initial begin
      bit found;
      repeat (3) step();
      chk("rst_an", anodos, 4'b1111);
      chk("rst_seg", segmentos, 7'b1111111);
      release_and_check_zero("boot");

      capture(4'd1, 4'd2, 4'd3, 4'd4);
      step();
      window(1'b0);
      chk("scan_dark", ndark(), 4);
      chk("scan_d0", npair(4'b1110, 7'b0011001), 3);
      chk("scan_d1", npair(4'b1101, 7'b0110000), 3);
      chk("scan_d2", npair(4'b1011, 7'b0100100), 3);
      chk("scan_d3", npair(4'b0111, 7'b1111001), 3);

      capture(4'd0, 4'd0, 4'd0, 4'd7);
      step();
      window(1'b0);
      chk("lz7_units", npair(4'b1110, 7'b1111000), 3);
      chk("lz7_dark", ndark(), 13);

      capture(4'd0, 4'd4, 4'd0, 4'd0);
      step();
      window(1'b0);
      chk("lz400_dark", ndark(), 7);
      chk("lz400_d2", npair(4'b1011, 7'b0011001), 3);
      chk("lz400_d1", npair(4'b1101, 7'b1000000), 3);
      chk("lz400_d3", npair(4'b0111, 7'b1000000), 0);

      window(1'b1);
      chk("hold_dark", ndark(), 7);
      chk("hold_d2", npair(4'b1011, 7'b0011001), 3);
      chk("hold_d0", npair(4'b1110, 7'b1000000), 3);

      capture(4'd0, 4'd0, 4'd0, 4'd12);
      step();
      window(1'b0);
      chk("dash_units", npair(4'b1110, 7'b0111111), 3);
      chk("dash_dark", ndark(), 13);

      capture(4'd1, 4'd2, 4'd3, 4'd4);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         step();
         if (anodos == 4'b1011) found = 1'b1;
      end
      chk("midscan_found", int'(found), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midscan_rst_an", anodos, 4'b1111);
      chk("midscan_rst_seg", segmentos, 7'b1111111);
      step();
      release_and_check_zero("midscan");

      for (int k = 0; k < 800; k++) begin
         escrever = ($urandom_range(0, 3) == 0);
         setseg1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         setseg2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         setseg3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         setseg4 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
         if ($urandom_range(0, 199) == 0) begin
            #2 reset_n = 1'b0;
            step();
            reset_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
